// File: rtl/issue_hazard_ctrl_pkg.sv
// rtl/issue_hazard_ctrl_pkg.sv - shared encodings for the issue-stage hazard controller
package issue_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int ROW_W = 5;

  typedef logic [1:0] unit_t;
  typedef logic [1:0] fwd_sel_t;

  localparam unit_t UNIT_ALU  = 2'd0;
  localparam unit_t UNIT_MEM  = 2'd1;
  localparam unit_t UNIT_MUL  = 2'd2;
  localparam unit_t UNIT_MISC = 2'd3;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_ALU = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_MUL = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

endpackage

// File: rtl/issue_hazard_ctrl_if.sv
// rtl/issue_hazard_ctrl_if.sv - decode, scoreboard and EX signals of the issue stage
// master = issue controller, slave = surrounding pipeline (decode, scoreboard, EX).
interface issue_hazard_ctrl_if #(
  parameter int PAYLOAD_W = 64
);
  import issue_hazard_ctrl_pkg::*;

  logic                 id_valid;
  logic                 id_ready;
  logic [REG_W-1:0]     id_rs;
  logic [REG_W-1:0]     id_rt;
  logic [REG_W-1:0]     id_rd;
  logic                 id_uses_rs;
  logic                 id_uses_rt;
  logic                 id_writes_rd;
  unit_t                id_unit;
  logic [PAYLOAD_W-1:0] id_payload;

  logic [REG_W-1:0]     sb_addr_a;
  logic [REG_W-1:0]     sb_addr_b;
  logic                 sb_pending_a;
  logic                 sb_pending_b;
  unit_t                sb_unit_a;
  unit_t                sb_unit_b;
  logic [ROW_W-1:0]     sb_row_a;
  logic [ROW_W-1:0]     sb_row_b;
  logic [REG_W-1:0]     sb_writeaddr;
  unit_t                sb_registerunit;
  logic                 sb_enablewrite;

  logic                 ex_valid;
  logic                 ex_ready;
  logic [PAYLOAD_W-1:0] ex_payload;
  logic [REG_W-1:0]     ex_rd;
  unit_t                ex_unit;
  fwd_sel_t             ex_fwd_sel_a;
  fwd_sel_t             ex_fwd_sel_b;

  modport master (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_writes_rd,
    input  id_unit, id_payload,
    output id_ready,
    output sb_addr_a, sb_addr_b, sb_writeaddr, sb_registerunit, sb_enablewrite,
    input  sb_pending_a, sb_pending_b, sb_unit_a, sb_unit_b, sb_row_a, sb_row_b,
    output ex_valid, ex_payload, ex_rd, ex_unit, ex_fwd_sel_a, ex_fwd_sel_b,
    input  ex_ready
  );

  modport slave (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_writes_rd,
    output id_unit, id_payload,
    input  id_ready,
    input  sb_addr_a, sb_addr_b, sb_writeaddr, sb_registerunit, sb_enablewrite,
    output sb_pending_a, sb_pending_b, sb_unit_a, sb_unit_b, sb_row_a, sb_row_b,
    input  ex_valid, ex_payload, ex_rd, ex_unit, ex_fwd_sel_a, ex_fwd_sel_b,
    output ex_ready
  );

endinterface

// File: rtl/issue_hazard_ctrl_operand_ready_chk.sv
// rtl/issue_hazard_ctrl_operand_ready_chk.sv - per-operand readiness and bypass source selection
module operand_ready_chk
  import issue_hazard_ctrl_pkg::*;
#(
  parameter logic [ROW_W-1:0] ALU_FWD_MASK = 5'b01111,
  parameter logic [ROW_W-1:0] MEM_FWD_MASK = 5'b00111,
  parameter logic [ROW_W-1:0] MUL_FWD_MASK = 5'b00011
) (
  input  logic             used,
  input  logic [REG_W-1:0] reg_addr,
  input  logic             pending,
  input  unit_t            unit,
  input  logic [ROW_W-1:0] row,
  output logic             ready,
  output fwd_sel_t         fwd_sel
);

  logic [ROW_W-1:0] mask;
  logic             live;
  logic             bypass;

  always_comb begin
    mask    = '0;
    fwd_sel = FWD_RF;
    case (unit)
      UNIT_ALU: mask = ALU_FWD_MASK;
      UNIT_MEM: mask = MEM_FWD_MASK;
      UNIT_MUL: mask = MUL_FWD_MASK;
      default:  mask = '0;
    endcase

    live   = used && (reg_addr != '0);
    bypass = live && pending && ((row & mask) != '0);
    ready  = !live || !pending || bypass;

    // Only a real bypass picks a forwarding path; every other ready case reads the RF.
    if (bypass) begin
      case (unit)
        UNIT_ALU: fwd_sel = FWD_ALU;
        UNIT_MEM: fwd_sel = FWD_MEM;
        UNIT_MUL: fwd_sel = FWD_MUL;
        default:  fwd_sel = FWD_RF;
      endcase
    end
  end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// rtl/issue_hazard_ctrl.sv - issue register, operand hazard stall, bypass select and scoreboard claim
// Optional ISS_STALL_CNT_EN adds stall_cycles / issue_count performance counters.
module issue_hazard_ctrl
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int               PAYLOAD_W    = 64,
  parameter logic [ROW_W-1:0] ALU_FWD_MASK = 5'b01111,
  parameter logic [ROW_W-1:0] MEM_FWD_MASK = 5'b00111,
  parameter logic [ROW_W-1:0] MUL_FWD_MASK = 5'b00011
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  issue_hazard_ctrl_if.master bus,
  output logic                hazard_stall
`ifdef ISS_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         issue_count
`endif
);

  state_t               state_q;
  state_t               state_d;
  logic [REG_W-1:0]     rs_q;
  logic [REG_W-1:0]     rt_q;
  logic [REG_W-1:0]     rd_q;
  logic                 uses_rs_q;
  logic                 uses_rt_q;
  logic                 writes_rd_q;
  unit_t                unit_q;
  logic [PAYLOAD_W-1:0] payload_q;

  logic held;
  logic ready_a;
  logic ready_b;
  logic hazard;
  logic ex_valid_c;
  logic fire;
  logic id_ready_c;
  logic load;

  operand_ready_chk #(
    .ALU_FWD_MASK (ALU_FWD_MASK),
    .MEM_FWD_MASK (MEM_FWD_MASK),
    .MUL_FWD_MASK (MUL_FWD_MASK)
  ) u_chk_a (
    .used     (uses_rs_q),
    .reg_addr (rs_q),
    .pending  (bus.sb_pending_a),
    .unit     (bus.sb_unit_a),
    .row      (bus.sb_row_a),
    .ready    (ready_a),
    .fwd_sel  (bus.ex_fwd_sel_a)
  );

  operand_ready_chk #(
    .ALU_FWD_MASK (ALU_FWD_MASK),
    .MEM_FWD_MASK (MEM_FWD_MASK),
    .MUL_FWD_MASK (MUL_FWD_MASK)
  ) u_chk_b (
    .used     (uses_rt_q),
    .reg_addr (rt_q),
    .pending  (bus.sb_pending_b),
    .unit     (bus.sb_unit_b),
    .row      (bus.sb_row_b),
    .ready    (ready_b),
    .fwd_sel  (bus.ex_fwd_sel_b)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    held       = (state_q == ST_HELD);
    hazard     = held && !(ready_a && ready_b);
    ex_valid_c = held && !hazard && !flush;
    fire       = ex_valid_c && bus.ex_ready;
    id_ready_c = !held || fire;
    load       = bus.id_valid && id_ready_c && !flush;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (bus.id_valid) state_d = ST_HELD;
        ST_HELD:  if (fire) state_d = bus.id_valid ? ST_HELD : ST_EMPTY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // A reload on the firing edge sees its scoreboard claim one cycle later, so no bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      uses_rs_q   <= 1'b0;
      uses_rt_q   <= 1'b0;
      writes_rd_q <= 1'b0;
      unit_q      <= UNIT_ALU;
      payload_q   <= '0;
    end else if (load) begin
      rs_q        <= bus.id_rs;
      rt_q        <= bus.id_rt;
      rd_q        <= bus.id_rd;
      uses_rs_q   <= bus.id_uses_rs;
      uses_rt_q   <= bus.id_uses_rt;
      writes_rd_q <= bus.id_writes_rd;
      unit_q      <= bus.id_unit;
      payload_q   <= bus.id_payload;
    end
  end

  assign bus.id_ready        = id_ready_c;
  assign bus.ex_valid        = ex_valid_c;
  assign bus.ex_payload      = payload_q;
  assign bus.ex_rd           = rd_q;
  assign bus.ex_unit         = unit_q;
  assign bus.sb_addr_a       = rs_q;
  assign bus.sb_addr_b       = rt_q;
  assign bus.sb_writeaddr    = rd_q;
  assign bus.sb_registerunit = unit_q;
  assign bus.sb_enablewrite  = fire && writes_rd_q && (rd_q != '0);
  assign hazard_stall        = hazard;

`ifdef ISS_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      if (hazard) stall_cycles <= stall_cycles + 32'd1;
      if (fire)   issue_count  <= issue_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// tb/tb_issue_hazard_ctrl.sv - directed-vector bench for issue_hazard_ctrl
module tb_issue_hazard_ctrl;

  logic clock;
  logic reset;
  logic flush;
  logic hazard_stall;
  int   n_vec;
  int   n_miscompare;
  int   n_claims;

  issue_hazard_ctrl_if #(.PAYLOAD_W(64)) bus ();

  issue_hazard_ctrl #(.PAYLOAD_W(64)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .bus          (bus),
    .hazard_stall (hazard_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic offer(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                       input logic wrd, input logic [1:0] unit, input logic [63:0] pl);
    bus.id_valid     = v;
    bus.id_rs        = rs;
    bus.id_uses_rs   = urs;
    bus.id_rt        = rt;
    bus.id_uses_rt   = urt;
    bus.id_rd        = rd;
    bus.id_writes_rd = wrd;
    bus.id_unit      = unit;
    bus.id_payload   = pl;
  endtask

  task automatic sb_a(input logic p, input logic [1:0] u, input logic [4:0] row);
    bus.sb_pending_a = p;
    bus.sb_unit_a    = u;
    bus.sb_row_a     = row;
  endtask

  task automatic sb_b(input logic p, input logic [1:0] u, input logic [4:0] row);
    bus.sb_pending_b = p;
    bus.sb_unit_b    = u;
    bus.sb_row_b     = row;
  endtask

  initial begin
    n_vec = 0;
    n_miscompare = 0;
    n_claims = 0;
    reset = 1'b0;
    flush = 1'b0;
    bus.ex_ready = 1'b0;
    offer(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 64'd0);
    sb_a(1'b0, 2'd0, 5'd0);
    sb_b(1'b0, 2'd0, 5'd0);

    // reset state
    settle();
    check_eq("rst_id_ready", bus.id_ready, 1);
    check_eq("rst_ex_valid", bus.ex_valid, 0);
    check_eq("rst_enablewrite", bus.sb_enablewrite, 0);
    check_eq("rst_hazard", hazard_stall, 0);
    check_eq("rst_payload", bus.ex_payload, 0);
    check_eq("rst_fwd", {bus.ex_fwd_sel_a, bus.ex_fwd_sel_b}, 0);
    tick();
    reset = 1'b1;

    // independent stream, ALU, zero-bubble reload
    bus.ex_ready = 1'b1;
    offer(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 2'd0, 64'hA1);
    settle();
    check_eq("ind_empty_ex_valid", bus.ex_valid, 0);
    tick();
    offer(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 2'd0, 64'hA2);
    settle();
    check_eq("ind_ex_valid", bus.ex_valid, 1);
    check_eq("ind_payload1", bus.ex_payload, 64'hA1);
    check_eq("ind_claim", {bus.sb_enablewrite, bus.sb_writeaddr, bus.sb_registerunit}, {1'b1, 5'd3, 2'd0});
    check_eq("ind_fwd", {bus.ex_fwd_sel_a, bus.ex_fwd_sel_b}, 0);
    check_eq("ind_id_ready", bus.id_ready, 1);
    check_eq("ind_sb_addr", {bus.sb_addr_a, bus.sb_addr_b}, {5'd1, 5'd2});
    tick();
    bus.id_valid = 1'b0;
    settle();
    check_eq("ind_payload2", bus.ex_payload, 64'hA2);
    check_eq("ind_claim2", bus.sb_enablewrite, 1);
    tick();
    settle();
    check_eq("ind_drain_ex_valid", bus.ex_valid, 0);
    check_eq("ind_drain_id_ready", bus.id_ready, 1);

    // ALU back-to-back: one stall, then bypass from ALU
    tick();
    offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd0, 64'hB1);
    tick();
    offer(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'd0, 64'hB2);
    settle();
    check_eq("alu_prod_claim", {bus.sb_enablewrite, bus.sb_writeaddr}, {1'b1, 5'd5});
    tick();
    bus.id_valid = 1'b0;
    sb_a(1'b1, 2'd0, 5'b10000);
    settle();
    check_eq("alu_stall", {hazard_stall, bus.ex_valid, bus.id_ready, bus.sb_enablewrite}, 4'b1000);
    check_eq("alu_sb_addr_a", bus.sb_addr_a, 5'd5);
    tick();
    sb_a(1'b1, 2'd0, 5'b01000);
    settle();
    check_eq("alu_issue", {hazard_stall, bus.ex_valid}, 2'b01);
    check_eq("alu_fwd_a", bus.ex_fwd_sel_a, 2'b01);
    check_eq("alu_cons_claim", {bus.sb_enablewrite, bus.sb_writeaddr}, {1'b1, 5'd6});
    tick();
    sb_a(1'b0, 2'd0, 5'd0);

    // MEM load-use: two stalls, then MEM bypass at row 00100
    offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd1, 64'hC1);
    tick();
    offer(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 2'd0, 64'hC2);
    settle();
    check_eq("mem_prod_claim", {bus.sb_enablewrite, bus.sb_writeaddr, bus.sb_registerunit}, {1'b1, 5'd7, 2'd1});
    tick();
    bus.id_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb_b(1'b1, 2'd1, 5'b10000 >> i);
      settle();
      check_eq($sformatf("mem_stall%0d", i), {hazard_stall, bus.ex_valid}, 2'b10);
      tick();
    end
    sb_b(1'b1, 2'd1, 5'b00100);
    settle();
    check_eq("mem_issue", {hazard_stall, bus.ex_valid, bus.sb_enablewrite}, 3'b011);
    check_eq("mem_fwd_b", {bus.ex_fwd_sel_a, bus.ex_fwd_sel_b}, {2'b00, 2'b10});
    tick();
    sb_b(1'b0, 2'd0, 5'd0);

    // misc-unit producer: never bypassed, wait for pending to clear
    offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd3, 64'hD1);
    tick();
    offer(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 2'd0, 64'hD2);
    tick();
    bus.id_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sb_a(1'b1, 2'd3, 5'b10000 >> i);
      settle();
      check_eq($sformatf("misc_stall%0d", i), {hazard_stall, bus.ex_valid, bus.ex_fwd_sel_a}, 4'b1000);
      tick();
    end
    sb_a(1'b0, 2'd3, 5'd0);
    settle();
    check_eq("misc_issue", {hazard_stall, bus.ex_valid, bus.ex_fwd_sel_a}, 4'b0100);
    check_eq("misc_payload", bus.ex_payload, 64'hD2);
    tick();

    // EX back-pressure: hold, no claim, then exactly one claim
    bus.ex_ready = 1'b0;
    offer(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 2'd2, 64'hE1);
    tick();
    offer(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 2'd2, 64'hE2);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_claims += int'(bus.sb_enablewrite);
      check_eq($sformatf("bp_hold%0d", i), {bus.ex_valid, bus.id_ready, bus.sb_enablewrite}, 3'b100);
      check_eq($sformatf("bp_payload%0d", i), bus.ex_payload, 64'hE1);
      tick();
    end
    bus.ex_ready = 1'b1;
    bus.id_valid = 1'b0;
    settle();
    n_claims += int'(bus.sb_enablewrite);
    check_eq("bp_release", {bus.ex_valid, bus.sb_writeaddr, bus.sb_registerunit}, {1'b1, 5'd4, 2'd2});
    tick();
    settle();
    n_claims += int'(bus.sb_enablewrite);
    check_eq("bp_claims", n_claims, 1);
    check_eq("bp_empty", bus.ex_valid, 0);
    tick();

    // flush during a MUL stall
    offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 2'd2, 64'hF1);
    tick();
    offer(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 2'd0, 64'hF2);
    tick();
    bus.id_valid = 1'b0;
    sb_a(1'b1, 2'd2, 5'b10000);
    settle();
    check_eq("mul_stall", {hazard_stall, bus.ex_valid}, 2'b10);
    tick();
    sb_a(1'b1, 2'd2, 5'b01000);
    flush = 1'b1;
    settle();
    check_eq("flush_no_issue", {bus.ex_valid, bus.sb_enablewrite}, 2'b00);
    tick();
    flush = 1'b0;
    sb_a(1'b1, 2'd2, 5'b00100);
    settle();
    check_eq("flush_empty", {bus.ex_valid, bus.id_ready, hazard_stall}, 3'b010);
    tick();
    sb_a(1'b0, 2'd0, 5'd0);

    // rd = 0: flushed first time, issued second time, never claims
    offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd0, 64'h51);
    tick();
    bus.id_valid = 1'b0;
    flush = 1'b1;
    settle();
    check_eq("rd0_flush", {bus.ex_valid, bus.sb_enablewrite}, 2'b00);
    tick();
    flush = 1'b0;
    bus.id_valid = 1'b1;
    tick();
    bus.id_valid = 1'b0;
    settle();
    check_eq("rd0_issue", {bus.ex_valid, bus.sb_enablewrite}, 2'b10);
    tick();

    // MUL bypass and asynchronous reset in the middle of a stall
    offer(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 2'd0, 64'h61);
    tick();
    bus.id_valid = 1'b0;
    sb_a(1'b1, 2'd2, 5'b00010);
    settle();
    check_eq("mul_fwd_a", {hazard_stall, bus.ex_valid, bus.ex_fwd_sel_a}, 4'b0111);
    bus.ex_ready = 1'b0;
    sb_a(1'b1, 2'd2, 5'b00100);
    #1;
    check_eq("mul_row_stall", hazard_stall, 1);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_stall", {bus.ex_valid, bus.sb_enablewrite, bus.id_ready, hazard_stall}, 4'b0010);
    tick();
    reset = 1'b1;
    bus.ex_ready = 1'b1;
    settle();
    check_eq("rst_after", {bus.ex_valid, bus.sb_enablewrite}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
